// File: rtl/sched_pkg.sv
// Shared types and defaults for the node scheduler.
// Holds the FSM state encoding, the default parameter values and a
// width helper used by the scheduler and its ticker.
package sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_STORE,
      ST_FETCH,
      ST_LOAD,
      ST_SEND,
      ST_WAIT
   } state_t;

   localparam int DEF_PERIOD  = 100;
   localparam int DEF_DEPTH   = 16;
   localparam int DEF_BURST   = 8;
   localparam int DEF_TIMEOUT = 255;

   // Bit width needed to hold values 0..v-1, never less than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/sched_ticker.sv
// Sample-interval ticker for the node scheduler.
// Counts 0..PERIOD-1 while enabled (held at 0 otherwise); each wrap
// raises tick_pend, which stays set until the FSM consumes it.
module sched_ticker
   import sched_pkg::*;
#(
   parameter int PERIOD = DEF_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic tick_clr,
   output logic tick_pend
);

   localparam int CW = clog2_min1(PERIOD);

   logic [CW-1:0] cnt_reg;
   logic          wrap;

   assign wrap = enable && (cnt_reg == CW'(PERIOD - 1));

   // Period counter: frozen at zero while the node is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (!enable || wrap) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Pending-tick latch: a new wrap wins over a same-cycle clear so it is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_pend <= 1'b0;
      end else if (wrap) begin
         tick_pend <= 1'b1;
      end else if (tick_clr) begin
         tick_pend <= 1'b0;
      end
   end

endmodule

// File: rtl/node_scheduler.sv
// Sensor-node scheduler: periodically samples a sensor into a ring buffer
// held in external memory and drains it to a radio in bursts.
// Optional feature: define SCHED_WATCHDOG_EN to bound the radio-busy wait
// with a TIMEOUT-cycle watchdog that aborts the burst and sets timeout_err.
module node_scheduler
   import sched_pkg::*;
#(
   parameter int         PERIOD  = DEF_PERIOD,
   parameter int         DEPTH   = DEF_DEPTH,
   parameter int         BURST   = DEF_BURST,
   parameter logic [7:0] BASE    = 8'h00,
   parameter int         TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   output logic                   sensor_enable,
   input  logic [7:0]             sensor_data,
   output logic [7:0]             mem_address,
   output logic [7:0]             mem_wdata,
   output logic                   mem_write,
   output logic                   mem_read,
   input  logic [7:0]             mem_rdata,
   output logic                   radio_enable,
   output logic                   radio_send,
   output logic [7:0]             radio_data,
   input  logic                   radio_busy,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fill,
   output logic                   overflow,
   output logic                   timeout_err
);

   localparam int AW = clog2_min1(DEPTH);
   localparam int FW = $clog2(DEPTH) + 1;

   state_t        state_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [FW-1:0] fill_reg;
   logic [7:0]    burst_cnt_reg;
   logic          burst_active_reg;
   logic          radio_enable_reg;
   logic [7:0]    radio_data_reg;
   logic [7:0]    mem_address_reg;
   logic          overflow_reg;
   logic          tick_pend;
   logic          tick_clr;

   // Ring pointer advance; explicit wrap keeps DEPTH=1 correct too.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A pending tick is consumed exactly when IDLE dispatches it to SAMPLE.
   assign tick_clr = (state_reg == ST_IDLE) && tick_pend && enable;

   sched_ticker #(
      .PERIOD (PERIOD)
   ) u_ticker (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .tick_clr  (tick_clr),
      .tick_pend (tick_pend)
   );

`ifdef SCHED_WATCHDOG_EN
   localparam int WW = clog2_min1(TIMEOUT + 1);
   logic [WW-1:0] wd_cnt_reg;
   logic          timeout_err_reg;
`endif

   // Main FSM: sequencing, ring-buffer bookkeeping and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         fill_reg         <= '0;
         burst_cnt_reg    <= '0;
         burst_active_reg <= 1'b0;
         radio_enable_reg <= 1'b0;
         radio_data_reg   <= '0;
         mem_address_reg  <= '0;
         overflow_reg     <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
         wd_cnt_reg       <= '0;
         timeout_err_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (tick_pend && enable) begin
                  state_reg <= ST_SAMPLE;
               end else if (burst_active_reg) begin
                  if (enable && (fill_reg != '0) && (burst_cnt_reg != '0)) begin
                     state_reg       <= ST_FETCH;
                     mem_address_reg <= BASE + 8'(rd_ptr_reg);
                  end else begin
                     // Burst cut short (disabled or drained while a sample ran).
                     burst_active_reg <= 1'b0;
                     burst_cnt_reg    <= '0;
                     radio_enable_reg <= 1'b0;
                  end
               end else if (enable && (fill_reg >= FW'(BURST)) && !radio_busy) begin
                  burst_active_reg <= 1'b1;
                  burst_cnt_reg    <= 8'(BURST);
                  radio_enable_reg <= 1'b1;
                  state_reg        <= ST_FETCH;
                  mem_address_reg  <= BASE + 8'(rd_ptr_reg);
               end
            end

            ST_SAMPLE: begin
               // Address is set up here so it is stable throughout STORE.
               state_reg       <= ST_STORE;
               mem_address_reg <= BASE + 8'(wr_ptr_reg);
            end

            ST_STORE: begin
               wr_ptr_reg <= ptr_inc(wr_ptr_reg);
               if (fill_reg == FW'(DEPTH)) begin
                  // Full: the slot just written held the oldest entry.
                  rd_ptr_reg   <= ptr_inc(rd_ptr_reg);
                  overflow_reg <= 1'b1;
               end else begin
                  fill_reg <= fill_reg + 1'b1;
               end
               state_reg <= ST_IDLE;
            end

            ST_FETCH: begin
               state_reg <= ST_LOAD;
            end

            ST_LOAD: begin
               radio_data_reg <= mem_rdata;
               state_reg      <= ST_SEND;
            end

            ST_SEND: begin
               rd_ptr_reg    <= ptr_inc(rd_ptr_reg);
               fill_reg      <= fill_reg - 1'b1;
               burst_cnt_reg <= burst_cnt_reg - 1'b1;
               state_reg     <= ST_WAIT;
            end

            ST_WAIT: begin
               if (!radio_busy) begin
                  state_reg <= ST_IDLE;
                  if ((burst_cnt_reg == '0) || (fill_reg == '0) || !enable) begin
                     burst_active_reg <= 1'b0;
                     burst_cnt_reg    <= '0;
                     radio_enable_reg <= 1'b0;
                  end
`ifdef SCHED_WATCHDOG_EN
                  wd_cnt_reg <= '0;
`endif
               end
`ifdef SCHED_WATCHDOG_EN
               else if (wd_cnt_reg == WW'(TIMEOUT - 1)) begin
                  // Radio stuck busy: abandon the burst.
                  state_reg        <= ST_IDLE;
                  burst_active_reg <= 1'b0;
                  burst_cnt_reg    <= '0;
                  radio_enable_reg <= 1'b0;
                  timeout_err_reg  <= 1'b1;
                  wd_cnt_reg       <= '0;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + 1'b1;
               end
`endif
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SCHED_WATCHDOG_EN
   assign timeout_err = timeout_err_reg;
`else
   assign timeout_err = 1'b0;
`endif

   // Strobes and the write-data gate are decoded straight from the state.
   assign sensor_enable = (state_reg == ST_SAMPLE);
   assign mem_write     = (state_reg == ST_STORE);
   assign mem_read      = (state_reg == ST_FETCH);
   assign radio_send    = (state_reg == ST_SEND);
   assign mem_wdata     = (state_reg == ST_STORE) ? sensor_data : 8'h00;

   // busy depends only on registered state, so it is as clean as the strobes.
   assign busy         = (state_reg != ST_IDLE) || burst_active_reg;
   assign mem_address  = mem_address_reg;
   assign radio_enable = radio_enable_reg;
   assign radio_data   = radio_data_reg;
   assign fill         = fill_reg;
   assign overflow     = overflow_reg;

endmodule

// File: doc/node_scheduler.md
NODE_SCHEDULER -- requirements
Module: node_scheduler

Interface
REQ-001 Parameter PERIOD, default 100: sample interval in clk cycles (>=8).
REQ-002 Parameter DEPTH, default 16: ring-buffer entries in memory, power of 2, <=128.
REQ-003 Parameter BURST, default 8: fill level that starts a radio burst, and the maximum bytes per burst (1..DEPTH).
REQ-004 Parameter BASE, default 8'h00: memory base address of the ring buffer.
REQ-005 Parameter TIMEOUT, default 255: radio-busy watchdog limit in cycles.
REQ-006 clk in 1: single clock; all logic on the rising edge.
REQ-007 rst in 1: reset, asynchronous and active-high.
REQ-008 enable in 1: global run enable.
REQ-009 sensor_enable out 1: one-cycle sample strobe; sensor_data is valid on the next cycle.
REQ-010 sensor_data in 8: sensor sample.
REQ-011 mem_address out 8, mem_wdata out 8, mem_write out 1, mem_read out 1: memory port; read data is valid 1 cycle after mem_read.
REQ-012 mem_rdata in 8: memory read data.
REQ-013 radio_enable out 1, radio_send out 1, radio_data out 8, radio_busy in 1: radio port.
REQ-014 busy out 1; fill out $clog2(DEPTH)+1; overflow out 1 (sticky); timeout_err out 1 (sticky).

Function
REQ-015 FSM states: IDLE, SAMPLE, STORE, FETCH, LOAD, SEND, WAIT.
REQ-016 Tick counter: counts 0..PERIOD-1 while enable=1; it is held at 0 while enable=0; a wrap sets tick_pend.
REQ-017 IDLE priority is: (1) tick_pend -> SAMPLE, clearing tick_pend; (2) burst active and fill>0 -> FETCH; (3) no burst, fill>=BURST and radio_busy=0 -> start burst (burst_cnt=BURST, radio_enable=1) and go to FETCH.
REQ-018 SAMPLE: sensor_enable=1 for exactly 1 cycle, then STORE.
REQ-019 STORE: mem_write=1, mem_address=BASE+wr_ptr, mem_wdata=sensor_data; wr_ptr increments mod DEPTH; then IDLE.
REQ-020 STORE when fill<DEPTH: fill increments.
REQ-021 STORE when fill==DEPTH: the oldest entry is overwritten, rd_ptr increments, fill is unchanged, and overflow is set.
REQ-022 FETCH: mem_read=1, mem_address=BASE+rd_ptr, 1 cycle; then LOAD.
REQ-023 LOAD: mem_rdata is registered into radio_data; then SEND.
REQ-024 SEND: radio_send=1 for 1 cycle; rd_ptr increments mod DEPTH, fill decrements and burst_cnt decrements; then WAIT.
REQ-025 WAIT: leave to IDLE on the first cycle with radio_busy=0, no earlier than the cycle after SEND.
REQ-026 Burst ends when burst_cnt==0 or fill==0; radio_enable deasserts in the same cycle the FSM returns to IDLE.
REQ-027 A tick during a burst is latched in tick_pend and serviced in IDLE before the next FETCH; no tick is lost unless a second tick occurs while tick_pend is set.
REQ-028 Deasserting enable lets the current state sequence complete; no new SAMPLE or burst starts; an active burst terminates at the next IDLE.
REQ-029 busy is 1 whenever state!=IDLE or a burst is active.
REQ-030 Outputs are registered, except the strobes, which are decoded directly from state.

Reset
REQ-031 rst=1 asynchronously forces IDLE and clears tick counter, tick_pend, pointers, fill, burst_cnt, overflow, timeout_err and radio_data, and drives all strobes/enables to 0, including mid-burst and mid-STORE.

Configuration
REQ-032 With SCHED_WATCHDOG_EN defined: a counter runs in WAIT; after TIMEOUT consecutive radio_busy=1 cycles it aborts the burst, returns to IDLE and sets timeout_err.
REQ-033 Without SCHED_WATCHDOG_EN: WAIT is unbounded and timeout_err is tied to 0.

Structure
REQ-034 Package sched_pkg holds the state enum and the default PERIOD/DEPTH/BURST/TIMEOUT constants.
REQ-035 Sub-module sched_ticker implements the period counter and the tick_pend latch.

Verification
REQ-036 PERIOD=10, radio idle, 3 ticks -> writes to 0x00,0x01,0x02 with the sensor values; fill=3; radio_send never asserted.
REQ-037 BURST=4, samples 0xA1..0xA4 -> burst of radio_data 0xA1,0xA2,0xA3,0xA4 in order; fill returns to 0; radio_enable drops afterwards.
REQ-038 DEPTH=4, BURST=4, radio_busy held 1, 6 samples -> overflow=1, fill=4, next burst sends samples 3..6.
REQ-039 A tick arriving in WAIT -> SAMPLE/STORE occurs before the next FETCH, and the sample is stored after the burst's remaining data.
REQ-040 rst pulsed in LOAD -> all outputs 0 in the same cycle; after release, fill=0 and the first write goes to BASE.
REQ-041 SCHED_WATCHDOG_EN, TIMEOUT=20, radio_busy stuck at 1 -> after 20 WAIT cycles, timeout_err=1, FSM in IDLE, radio_enable=0.
